serial_bit_source: RTL and testbench

Parallel-to-serial stage that feeds the serial sequence-detector input `x`. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock. A one-word holding register lets consecutive words stream with no idle gap between frames. It sits directly upstream of the detector, and its `x` output drives the detector's `x` input.

---
 rtl/serial_bit_source.sv | 120 ++++++++++++
 tb/tb_serial_bit_source.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_bit_source.sv
// serial_bit_source: WIDTH-bit words in over valid/ready, one bit per clk out on x.
// ports: clk, reset (async low), din/din_valid/din_ready in; x/x_valid/x_last out.
module serial_bit_source #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             x_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_shifted;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;

  assign din_ready = reset & ~hold_full;
  assign accept    = din_valid & din_ready;
  assign last      = (state == SHIFT) & (cnt == CNT_LAST);

  generate
    if (MSB_FIRST) begin : g_msb
      assign sh_shifted = {sh[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign sh_shifted = {1'b0, sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = SHIFT;
      end
      SHIFT: begin
        if (last && !hold_full && !accept)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    x_valid = (state == SHIFT);
    x_last  = last;
    x       = 1'b0;
    if (state == SHIFT)
      x = MSB_FIRST ? sh[WIDTH-1] : sh[0];
  end

  // On the final-bit edge a held word wins; since hold_full blocks
  // din_ready, hold is never drained and filled on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sh  <= din;
            cnt <= '0;
          end
        end
        SHIFT: begin
          if (last) begin
            cnt <= '0;
            if (hold_full) begin
              sh        <= hold;
              hold_full <= 1'b0;
            end else if (accept) begin
              sh <= din;
            end else begin
              sh <= sh_shifted;
            end
          end else begin
            sh  <= sh_shifted;
            cnt <= cnt + CW'(1);
            if (accept) begin
              hold      <= din;
              hold_full <= 1'b1;
            end
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// tb_serial_bit_source: directed checks of serial_bit_source.
// u_msb is MSB-first, u_lsb is LSB-first; both share clk and reset.
module tb_serial_bit_source;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       x;
  logic       x_valid;
  logic       x_last;
  logic [7:0] din2;
  logic       din_valid2;
  logic       din_ready2;
  logic       x2;
  logic       x_valid2;
  logic       x_last2;

  int vectors;
  int errs;

  logic [7:0] words [3];
  logic [7:0] w;
  logic       ex;
  logic       er;

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .x         (x),
    .x_valid   (x_valid),
    .x_last    (x_last)
  );

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .reset     (reset),
    .din       (din2),
    .din_valid (din_valid2),
    .din_ready (din_ready2),
    .x         (x2),
    .x_valid   (x_valid2),
    .x_last    (x_last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ex_x,
                         input logic ex_v, input logic ex_l);
    chk({tag, ".x"}, x, ex_x);
    chk({tag, ".x_valid"}, x_valid, ex_v);
    chk({tag, ".x_last"}, x_last, ex_l);
  endtask

  initial begin
    vectors    = 0;
    errs       = 0;
    words[0]   = 8'hA5;
    words[1]   = 8'h3C;
    words[2]   = 8'hFF;
    reset      = 1'b0;
    din        = 8'hA5;
    din_valid  = 1'b1;
    din2       = 8'h06;
    din_valid2 = 1'b1;

    // reset held two cycles with valid offered
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_out("rst", 1'b0, 1'b0, 1'b0);
      chk("rst.din_ready", din_ready, 1'b0);
      chk("rst.x_valid2", x_valid2, 1'b0);
      chk("rst.din_ready2", din_ready2, 1'b0);
    end
    din_valid  = 1'b0;
    din_valid2 = 1'b0;
    reset      = 1'b1;
    #1;
    chk("rel.din_ready", din_ready, 1'b1);
    chk("rel.din_ready2", din_ready2, 1'b1);
    @(negedge clk);
    chk_out("rel.idle", 1'b0, 1'b0, 1'b0);
    chk("rel.x_valid2", x_valid2, 1'b0);

    // single word 8'hA5 MSB-first, 8'h06 LSB-first in parallel
    din        = 8'hA5;
    din_valid  = 1'b1;
    din2       = 8'h06;
    din_valid2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      din_valid  = 1'b0;
      din_valid2 = 1'b0;
      w  = 8'b1010_0101;
      ex = w[7-k];
      chk_out("single", ex, 1'b1, k == 7);
      w  = 8'b0000_0110;
      ex = w[k];
      chk("lsb.x", x2, ex);
      chk("lsb.x_valid", x_valid2, 1'b1);
      chk("lsb.x_last", x_last2, k == 7);
    end
    @(negedge clk);
    chk_out("single.idle", 1'b0, 1'b0, 1'b0);
    chk("lsb.idle", x_valid2, 1'b0);

    // back-to-back A5, 3C, FF with backpressure on FF
    din       = 8'hA5;
    din_valid = 1'b1;
    chk("b2b.rdy0", din_ready, 1'b1);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 1)  din = 8'h3C;
      if (c == 2)  din = 8'hFF;
      if (c == 10) din_valid = 1'b0;
      if (c <= 24) begin
        w  = words[(c-1)/8];
        ex = w[7-((c-1)%8)];
        chk_out("b2b", ex, 1'b1, ((c-1)%8) == 7);
      end else begin
        chk_out("b2b.idle", 1'b0, 1'b0, 1'b0);
      end
      er = (c == 1) || (c == 9) || (c >= 17);
      chk("b2b.din_ready", din_ready, er);
    end

    // reset mid-word with a held word
    din       = 8'hA5;
    din_valid = 1'b1;
    @(negedge clk);
    din = 8'h3C;
    chk_out("mid.b0", 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    chk("mid.held", din_ready, 1'b0);
    chk_out("mid.b1", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("mid.b2", 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_out("mid.async", 1'b0, 1'b0, 1'b0);
    chk("mid.async.din_ready", din_ready, 1'b0);
    @(negedge clk);
    chk_out("mid.inrst", 1'b0, 1'b0, 1'b0);
    reset     = 1'b1;
    din       = 8'h81;
    din_valid = 1'b1;
    #1;
    chk("mid.rel.din_ready", din_ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      din_valid = 1'b0;
      ex = (k == 0) || (k == 7);
      chk_out("post", ex, 1'b1, k == 7);
    end
    @(negedge clk);
    chk_out("post.idle", 1'b0, 1'b0, 1'b0);
    chk("post.din_ready", din_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
